dmem_arbiter: RTL and testbench

//  Two-requester round-robin arbiter sharing the single dmem request/response port (SRAM/UART/par-txrx decode).
//  M0 = CPU load/store port, M1 = SIMD vector load/store unit. In-order response routing via grant-ID FIFO.

---
 rtl/dmem_arbiter.sv | 147 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one dmem port between the CPU (M0) and SIMD unit (M1).
// Load responses return in order, steered by a FIFO of grant IDs.
module dmem_arbiter #(
   parameter int MAX_OUTST = 2,
   parameter bit M0_FIRST  = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] m0_req_addr,
   input  logic [31:0] m0_req_wdata,
   input  logic [3:0]  m0_req_wmask,
   input  logic        m0_req_write,
   input  logic        m0_req_valid,
   output logic        m0_req_ready,
   output logic        m0_resp_valid,
   input  logic        m0_resp_ready,
   output logic [31:0] m0_resp_rdata,
   input  logic [31:0] m1_req_addr,
   input  logic [31:0] m1_req_wdata,
   input  logic [3:0]  m1_req_wmask,
   input  logic        m1_req_write,
   input  logic        m1_req_valid,
   output logic        m1_req_ready,
   output logic        m1_resp_valid,
   input  logic        m1_resp_ready,
   output logic [31:0] m1_resp_rdata,
   output logic [31:0] s_req_addr,
   output logic [31:0] s_req_wdata,
   output logic [3:0]  s_req_wmask,
   output logic        s_req_write,
   output logic        s_req_valid,
   input  logic        s_req_ready,
   input  logic        s_resp_valid,
   output logic        s_resp_ready,
   input  logic [31:0] s_resp_rdata,
   output logic        resp_err
);

   localparam int PW    = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
   localparam int CW    = $clog2(MAX_OUTST + 1);
   localparam int DEPTH = 2 ** PW;

   logic             lock_q, lock_d;
   logic             lock_id_q, lock_id_d;
   logic             prio_q, prio_d;
   logic [DEPTH-1:0] mem_q, mem_d;
   logic [PW-1:0]    wptr_q, wptr_d;
   logic [PW-1:0]    rptr_q, rptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             err_q, err_d;

   logic gnt, gv, gw, stall, hs, push, pop, empty, head;

   always_comb begin
      gnt = prio_q;
      if (lock_q)
         gnt = lock_id_q;
      else if (m0_req_valid && !m1_req_valid)
         gnt = 1'b0;
      else if (m1_req_valid && !m0_req_valid)
         gnt = 1'b1;

      gv = gnt ? m1_req_valid : m0_req_valid;
      gw = gnt ? m1_req_write : m0_req_write;
      s_req_addr  = gnt ? m1_req_addr  : m0_req_addr;
      s_req_wdata = gnt ? m1_req_wdata : m0_req_wdata;
      s_req_wmask = gnt ? m1_req_wmask : m0_req_wmask;
      s_req_write = gw;

      // stall uses the pre-pop count, so a same-cycle pop never unstalls
      stall = gv && !gw && (cnt_q >= CW'(MAX_OUTST));
      s_req_valid  = gv && !stall && !reset;
      m0_req_ready = !gnt && s_req_ready && !stall && !reset;
      m1_req_ready =  gnt && s_req_ready && !stall && !reset;
      hs = s_req_valid && s_req_ready;

      empty = (cnt_q == '0);
      head  = mem_q[rptr_q];
      m0_resp_valid = 1'b0;
      m1_resp_valid = 1'b0;
      m0_resp_rdata = '0;
      m1_resp_rdata = '0;
      s_resp_ready  = 1'b0;
      if (reset) begin
         s_resp_ready = 1'b0;
      end else if (empty) begin
         s_resp_ready = 1'b1;
      end else if (head) begin
         m1_resp_valid = s_resp_valid;
         m1_resp_rdata = s_resp_rdata;
         s_resp_ready  = m1_resp_ready;
      end else begin
         m0_resp_valid = s_resp_valid;
         m0_resp_rdata = s_resp_rdata;
         s_resp_ready  = m0_resp_ready;
      end

      push = hs && !gw;
      pop  = s_resp_valid && s_resp_ready && !empty;

      lock_d    = s_req_valid && !s_req_ready;
      lock_id_d = gnt;
      prio_d    = hs ? ~gnt : prio_q;

      mem_d  = mem_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (push) begin
         mem_d[wptr_q] = gnt;
         wptr_d = (wptr_q == PW'(MAX_OUTST - 1)) ? '0 : wptr_q + PW'(1);
      end
      if (pop)
         rptr_d = (rptr_q == PW'(MAX_OUTST - 1)) ? '0 : rptr_q + PW'(1);
      if (push && !pop)
         cnt_d = cnt_q + CW'(1);
      else if (pop && !push)
         cnt_d = cnt_q - CW'(1);

      err_d = err_q || (s_resp_valid && empty && !reset);
   end

   assign resp_err = err_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lock_q    <= 1'b0;
         lock_id_q <= 1'b0;
         prio_q    <= ~M0_FIRST;
         mem_q     <= '0;
         wptr_q    <= '0;
         rptr_q    <= '0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         lock_q    <= lock_d;
         lock_id_q <= lock_id_d;
         prio_q    <= prio_d;
         mem_q     <= mem_d;
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: arbitration, lock, stall at full FIFO,
// response routing, drain error and asynchronous reset.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] m0_req_addr, m0_req_wdata, m0_resp_rdata;
   logic [3:0]  m0_req_wmask;
   logic        m0_req_write, m0_req_valid, m0_req_ready;
   logic        m0_resp_valid, m0_resp_ready;
   logic [31:0] m1_req_addr, m1_req_wdata, m1_resp_rdata;
   logic [3:0]  m1_req_wmask;
   logic        m1_req_write, m1_req_valid, m1_req_ready;
   logic        m1_resp_valid, m1_resp_ready;
   logic [31:0] s_req_addr, s_req_wdata, s_resp_rdata;
   logic [3:0]  s_req_wmask;
   logic        s_req_write, s_req_valid, s_req_ready;
   logic        s_resp_valid, s_resp_ready, resp_err;

   int checks = 0;
   int errors = 0;

   dmem_arbiter #(.MAX_OUTST(2), .M0_FIRST(1'b1)) dut (
      .clk(clk), .reset(reset),
      .m0_req_addr(m0_req_addr), .m0_req_wdata(m0_req_wdata),
      .m0_req_wmask(m0_req_wmask), .m0_req_write(m0_req_write),
      .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready),
      .m0_resp_valid(m0_resp_valid), .m0_resp_ready(m0_resp_ready),
      .m0_resp_rdata(m0_resp_rdata),
      .m1_req_addr(m1_req_addr), .m1_req_wdata(m1_req_wdata),
      .m1_req_wmask(m1_req_wmask), .m1_req_write(m1_req_write),
      .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready),
      .m1_resp_valid(m1_resp_valid), .m1_resp_ready(m1_resp_ready),
      .m1_resp_rdata(m1_resp_rdata),
      .s_req_addr(s_req_addr), .s_req_wdata(s_req_wdata),
      .s_req_wmask(s_req_wmask), .s_req_write(s_req_write),
      .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
      .s_resp_valid(s_resp_valid), .s_resp_ready(s_resp_ready),
      .s_resp_rdata(s_resp_rdata), .resp_err(resp_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
   endtask

   initial begin
      reset = 1'b1;
      m0_req_addr = '0; m0_req_wdata = '0; m0_req_wmask = '0;
      m0_req_write = 1'b0; m0_req_valid = 1'b1; m0_resp_ready = 1'b1;
      m1_req_addr = '0; m1_req_wdata = '0; m1_req_wmask = '0;
      m1_req_write = 1'b0; m1_req_valid = 1'b0; m1_resp_ready = 1'b1;
      s_req_ready = 1'b1; s_resp_valid = 1'b0; s_resp_rdata = '0;
      step();
      check("rst_s_req_valid", 32'(s_req_valid), 0);
      check("rst_m0_req_ready", 32'(m0_req_ready), 0);
      check("rst_resp_err", 32'(resp_err), 0);
      m0_req_valid = 1'b0;
      reset = 1'b0;
      step();

      // single M0 load and its response
      m0_req_valid = 1'b1; m0_req_addr = 32'h0000_0100;
      settle();
      check("t1_s_req_valid", 32'(s_req_valid), 1);
      check("t1_s_req_addr", s_req_addr, 32'h0000_0100);
      check("t1_m0_ready", 32'(m0_req_ready), 1);
      check("t1_m1_ready", 32'(m1_req_ready), 0);
      step();
      m0_req_valid = 1'b0;
      s_resp_valid = 1'b1; s_resp_rdata = 32'hDEAD_BEEF;
      settle();
      check("t1_m0_resp_valid", 32'(m0_resp_valid), 1);
      check("t1_m0_rdata", m0_resp_rdata, 32'hDEAD_BEEF);
      check("t1_m1_resp_valid", 32'(m1_resp_valid), 0);
      check("t1_s_resp_ready", 32'(s_resp_ready), 1);
      step();
      s_resp_valid = 1'b0;
      settle();
      check("t1_resp_err", 32'(resp_err), 0);

      // alternating grants, stall at full, in-order routing
      do_reset();
      m0_req_valid = 1'b1; m0_req_addr = 32'h200;
      m1_req_valid = 1'b1; m1_req_addr = 32'h300;
      settle();
      check("t2a_addr", s_req_addr, 32'h200);
      check("t2a_m0_ready", 32'(m0_req_ready), 1);
      check("t2a_m1_ready", 32'(m1_req_ready), 0);
      step();
      check("t2b_addr", s_req_addr, 32'h300);
      check("t2b_m1_ready", 32'(m1_req_ready), 1);
      step();
      s_resp_valid = 1'b1; s_resp_rdata = 32'hA0;
      settle();
      check("t2c_stall_valid", 32'(s_req_valid), 0);
      check("t2c_stall_m0_ready", 32'(m0_req_ready), 0);
      check("t2c_m0_resp_valid", 32'(m0_resp_valid), 1);
      check("t2c_m0_rdata", m0_resp_rdata, 32'hA0);
      check("t2c_m1_resp_valid", 32'(m1_resp_valid), 0);
      step();
      s_resp_rdata = 32'hA1;
      settle();
      check("t2d_addr", s_req_addr, 32'h200);
      check("t2d_m0_ready", 32'(m0_req_ready), 1);
      check("t2d_m1_resp_valid", 32'(m1_resp_valid), 1);
      check("t2d_m1_rdata", m1_resp_rdata, 32'hA1);
      check("t2d_m0_resp_valid", 32'(m0_resp_valid), 0);
      check("t2d_m0_rdata", m0_resp_rdata, 0);
      step();
      s_resp_rdata = 32'hA2;
      settle();
      check("t2e_addr", s_req_addr, 32'h300);
      check("t2e_m1_ready", 32'(m1_req_ready), 1);
      check("t2e_m0_rdata", m0_resp_rdata, 32'hA2);
      check("t2e_m0_resp_valid", 32'(m0_resp_valid), 1);
      step();
      m0_req_valid = 1'b0; m1_req_valid = 1'b0;
      s_resp_rdata = 32'hA3;
      settle();
      check("t2f_m1_resp_valid", 32'(m1_resp_valid), 1);
      check("t2f_m1_rdata", m1_resp_rdata, 32'hA3);
      step();
      s_resp_valid = 1'b0;
      settle();
      check("t2_resp_err", 32'(resp_err), 0);

      // M1 store held by lock while fabric is busy
      do_reset();
      s_req_ready = 1'b0;
      m1_req_valid = 1'b1; m1_req_write = 1'b1; m1_req_addr = 32'h400;
      m1_req_wdata = 32'h55; m1_req_wmask = 4'hF;
      settle();
      check("t3_c1_addr", s_req_addr, 32'h400);
      check("t3_c1_write", 32'(s_req_write), 1);
      check("t3_c1_m1_ready", 32'(m1_req_ready), 0);
      step();
      m0_req_valid = 1'b1; m0_req_write = 1'b0; m0_req_addr = 32'h500;
      for (int i = 0; i < 2; i++) begin
         settle();
         check("t3_hold_addr", s_req_addr, 32'h400);
         check("t3_hold_m0_ready", 32'(m0_req_ready), 0);
         step();
      end
      s_req_ready = 1'b1;
      settle();
      check("t3_c4_m1_ready", 32'(m1_req_ready), 1);
      check("t3_c4_wdata", s_req_wdata, 32'h55);
      check("t3_c4_wmask", 32'(s_req_wmask), 32'hF);
      step();
      m1_req_valid = 1'b0; m1_req_write = 1'b0;
      settle();
      check("t3_c5_addr", s_req_addr, 32'h500);
      check("t3_c5_m0_ready", 32'(m0_req_ready), 1);
      step();
      m0_req_valid = 1'b0;
      s_resp_valid = 1'b1; s_resp_rdata = 32'h77;
      settle();
      check("t3_m0_resp_valid", 32'(m0_resp_valid), 1);
      check("t3_m0_rdata", m0_resp_rdata, 32'h77);
      step();
      s_resp_valid = 1'b0;

      // three back-to-back M0 loads, third stalls until a pop
      do_reset();
      m0_req_valid = 1'b1; m0_req_addr = 32'h600;
      settle();
      check("t4_l1_ready", 32'(m0_req_ready), 1);
      step();
      check("t4_l2_ready", 32'(m0_req_ready), 1);
      step();
      check("t4_l3_stall", 32'(m0_req_ready), 0);
      check("t4_l3_s_valid", 32'(s_req_valid), 0);
      step();
      check("t4_l3_stall2", 32'(m0_req_ready), 0);
      s_resp_valid = 1'b1; s_resp_rdata = 32'h11;
      settle();
      check("t4_pop_no_unstall", 32'(m0_req_ready), 0);
      check("t4_pop_rdata", m0_resp_rdata, 32'h11);
      step();
      s_resp_valid = 1'b0;
      settle();
      check("t4_l3_ready", 32'(m0_req_ready), 1);
      step();
      m0_req_write = 1'b1;
      settle();
      check("t4_store_full_ready", 32'(m0_req_ready), 1);
      check("t4_store_full_valid", 32'(s_req_valid), 1);
      step();
      m0_req_write = 1'b0;

      // async reset with two loads outstanding, then a stale response
      #2;
      reset = 1'b1;
      s_resp_valid = 1'b1; s_resp_rdata = 32'h99;
      #1;
      check("t5_rst_s_valid", 32'(s_req_valid), 0);
      check("t5_rst_m0_ready", 32'(m0_req_ready), 0);
      check("t5_rst_s_resp_ready", 32'(s_resp_ready), 0);
      check("t5_rst_m0_resp_valid", 32'(m0_resp_valid), 0);
      check("t5_rst_err", 32'(resp_err), 0);
      step();
      reset = 1'b0;
      m0_req_valid = 1'b0;
      settle();
      check("t5_drain_ready", 32'(s_resp_ready), 1);
      check("t5_drain_m0_valid", 32'(m0_resp_valid), 0);
      check("t5_drain_m1_valid", 32'(m1_resp_valid), 0);
      step();
      s_resp_valid = 1'b0;
      settle();
      check("t5_err_set", 32'(resp_err), 1);
      step();
      step();
      check("t5_err_sticky", 32'(resp_err), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
